// File: rtl/fib_capture_fifo.sv
// Capture FIFO for the Fibonacci core output: pushes each new value, drains over Wishbone,
// and raises a level interrupt once the fill level reaches a programmable threshold.
module fib_capture_fifo #(
   parameter int          WIDTH   = 30,
   parameter int          DEPTH   = 8,
   parameter logic [31:0] CTRL_ID = 32'h46494643
) (
   input  logic             wb_clk_i,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] value_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [5:0]       wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   output logic             irq_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = (LW > 4) ? LW : 4;

   localparam logic [5:0] ADR_STATUS = 6'h00;
   localparam logic [5:0] ADR_POP    = 6'h04;
   localparam logic [5:0] ADR_CTRL   = 6'h08;
   localparam logic [5:0] ADR_ID     = 6'h0C;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             overflow_q, overflow_d;
   logic             capture_en_q, capture_en_d;
   logic [3:0]       thresh_q, thresh_d;
   logic             last_valid_q, last_valid_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d;
   logic             irq_q, irq_d;

   logic        req, rd_req, wr_req;
   logic        empty, full;
   logic        clear, en_rise, w1c;
   logic        cap_att, pop_ok, push_ok;
   logic [31:0] rdata;

   logic unused_dat;
   assign unused_dat = ^{wbs_dat_i[31:8], wbs_dat_i[3]};

   always_comb begin
      req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
      rd_req  = req & ~wbs_we_i;
      wr_req  = req & wbs_we_i;
      empty   = (level_q == '0);
      full    = (level_q == LW'(DEPTH));
      clear   = wr_req && (wbs_adr_i == ADR_CTRL) && wbs_dat_i[1];
      en_rise = wr_req && (wbs_adr_i == ADR_CTRL) && wbs_dat_i[0] && !capture_en_q;
      w1c     = wr_req && (wbs_adr_i == ADR_STATUS) && wbs_dat_i[2];
      pop_ok  = rd_req && (wbs_adr_i == ADR_POP) && !empty;
      cap_att = capture_en_q && (!last_valid_q || (value_i != last_q));
      // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
      push_ok = cap_att && (!full || pop_ok) && !clear;
   end

   always_comb begin
      rdata = '0;
      case (wbs_adr_i)
         ADR_STATUS: begin
            rdata[8 +: LW] = level_q;
            rdata[2]       = overflow_q;
            rdata[1]       = full;
            rdata[0]       = empty;
         end
         ADR_POP: begin
            if (!empty) rdata[WIDTH-1:0] = mem_q[rd_ptr_q];
         end
         ADR_CTRL: begin
            rdata[7:4] = thresh_q;
            rdata[0]   = capture_en_q;
         end
         ADR_ID:  rdata = CTRL_ID;
         default: rdata = '0;
      endcase
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      overflow_d   = overflow_q;
      capture_en_d = capture_en_q;
      thresh_d     = thresh_q;
      last_valid_d = last_valid_q;
      last_d       = last_q;

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
         level_d = level_q + LW'(push_ok) - LW'(pop_ok);
      end

      // Dropped samples still update last_q so a held value is not retried every cycle.
      if (cap_att && !clear) begin
         last_d       = value_i;
         last_valid_d = 1'b1;
      end
      if (clear || en_rise) last_valid_d = 1'b0;

      if (w1c) overflow_d = 1'b0;
      if (cap_att && full && !pop_ok && !clear) overflow_d = 1'b1;

      if (wr_req && (wbs_adr_i == ADR_CTRL)) begin
         capture_en_d = wbs_dat_i[0];
         thresh_d     = wbs_dat_i[7:4];
      end

      ack_d = req;
      dat_d = rd_req ? rdata : 32'd0;
      irq_d = (thresh_d != 4'd0) && (CW'(level_d) >= CW'(thresh_d));
   end

   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         overflow_q   <= 1'b0;
         capture_en_q <= 1'b0;
         thresh_q     <= '0;
         last_valid_q <= 1'b0;
         last_q       <= '0;
         ack_q        <= 1'b0;
         dat_q        <= '0;
         irq_q        <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         overflow_q   <= overflow_d;
         capture_en_q <= capture_en_d;
         thresh_q     <= thresh_d;
         last_valid_q <= last_valid_d;
         last_q       <= last_d;
         ack_q        <= ack_d;
         dat_q        <= dat_d;
         irq_q        <= irq_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= value_i;
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign irq_o     = irq_q;

endmodule
